// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing for the FIFO read streamer.
// Buffer depth covers one word in flight plus two-deep backpressure slack.
package fifo_stream_pkg;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 256;
    localparam int BUF_DEPTH  = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [1:0]        buf_ptr_t;

    function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
        return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? buf_ptr_t'(0) : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_stream_skid_buf.sv
// Three-entry circular buffer absorbing the FIFO's registered read latency.
// Head word is presented directly; occupancy drives the stream valid.
module fifo_stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [1:0]   o_occ,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_mem [0:BUF_DEPTH-1];
    buf_ptr_t     r_wptr;
    buf_ptr_t     r_rptr;
    logic [1:0]   r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (i_push) r_wptr <= ptr_inc(r_wptr);
            if (i_pop)  r_rptr <= ptr_inc(r_rptr);
            unique case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone qualifies the contents.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rptr];

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(i_push && r_occ == 2'd3));
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(i_pop && r_occ == 2'd0));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains the FIFO into a valid/ready stream with burst framing on m_last.
// Pops are issued from registered occupancy only, so m_ready never reaches fifo_rd_en.
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W    = fifo_stream_pkg::DATA_W,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [31:0]       words_out
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    logic        r_en;
    logic        r_inflight;
    logic [7:0]  r_beat;
    logic [31:0] r_words;
    logic [1:0]  w_occ;
    logic [2:0]  w_held;
    logic        w_pop;

    fifo_stream_skid_buf #(
        .W (DATA_W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_din  (fifo_rd_data),
        .i_pop  (w_pop),
        .o_occ  (w_occ),
        .o_head (m_data)
    );

    // r_en keeps pops off while reset is asserted, independent of fifo_empty.
    assign w_held     = {1'b0, w_occ} + {2'b00, r_inflight};
    assign fifo_rd_en = r_en && !fifo_empty && (w_held < 3'(BUF_DEPTH));
    assign m_valid    = (w_occ != 2'd0);
    assign w_pop      = m_valid && m_ready;
    assign m_last     = m_valid && (r_beat == LAST_BEAT);
    assign words_out  = r_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_inflight <= 1'b0;
            r_beat     <= '0;
            r_words    <= '0;
        end else begin
            r_en       <= 1'b1;
            r_inflight <= fifo_rd_en;
            if (w_pop) begin
                r_words <= r_words + 32'd1;
                r_beat  <= (r_beat == LAST_BEAT) ? 8'd0 : r_beat + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural FIFO and beat scoreboard.
// A second instance is built with BURST_LEN=1.
module tb_fifo_rd_streamer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_empty, a_rd_en, a_valid, a_ready, a_last;
    logic [31:0] a_rd_data, a_data, a_words;
    logic        b_empty, b_rd_en, b_valid, b_ready, b_last;
    logic [31:0] b_rd_data, b_data, b_words;

    fifo_rd_streamer #(.DATA_W(32), .BURST_LEN(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty(a_empty), .fifo_rd_en(a_rd_en), .fifo_rd_data(a_rd_data),
        .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data),
        .m_last(a_last), .words_out(a_words)
    );

    fifo_rd_streamer #(.DATA_W(32), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty(b_empty), .fifo_rd_en(b_rd_en), .fifo_rd_data(b_rd_data),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data),
        .m_last(b_last), .words_out(b_words)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural FIFOs: registered read, flushed while reset is held.
    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];
    int a_wcnt = 0, a_rcnt = 0, b_wcnt = 0, b_rcnt = 0;
    assign a_empty = (a_wcnt == a_rcnt);
    assign b_empty = (b_wcnt == b_rcnt);

    always @(posedge clk) begin
        if (!rst_n) a_rcnt <= a_wcnt;
        else if (a_rd_en) begin
            a_rd_data <= a_mem[a_rcnt[7:0]];
            a_rcnt    <= a_rcnt + 1;
        end
        if (!rst_n) b_rcnt <= b_wcnt;
        else if (b_rd_en) begin
            b_rd_data <= b_mem[b_rcnt[7:0]];
            b_rcnt    <= b_rcnt + 1;
        end
    end

    logic [31:0] exp_q [$];
    logic [31:0] b_exp_q [$];
    int cyc = 0;
    always @(posedge clk) cyc++;

    int exp_beat = 0, lasts = 0, b_lasts = 0;
    int pops = 0, hs = 0, max_held = 0, rd_pulses = 0;
    int first_rd = -1, first_val = -1, stable_err = 0;
    logic stall_prev = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (a_rd_en) begin
            rd_pulses++;
            pops++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (pops - hs > max_held) max_held = pops - hs;
        if (a_valid && first_val < 0) first_val = cyc;
        if (stall_prev && (!a_valid || a_data !== prev_data)) stable_err++;
        stall_prev = a_valid && !a_ready;
        prev_data  = a_data;
        if (a_valid && a_ready) begin
            if (exp_q.size() == 0) check("extra_beat", a_data, 32'hdead);
            else check("data", a_data, exp_q.pop_front());
            check("last", a_last, exp_beat == 15);
            if (a_last) lasts++;
            exp_beat = (exp_beat + 1) % 16;
            hs++;
        end
        if (b_valid && b_ready) begin
            if (b_exp_q.size() == 0) check("b_extra_beat", b_data, 32'hdead);
            else check("b_data", b_data, b_exp_q.pop_front());
            if (b_last) b_lasts++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] v);
        a_mem[a_wcnt[7:0]] = v;
        a_wcnt++;
        exp_q.push_back(v);
    endtask

    task automatic push_b(input logic [31:0] v);
        b_mem[b_wcnt[7:0]] = v;
        b_wcnt++;
        b_exp_q.push_back(v);
    endtask

    task automatic rst_assert();
        rst_n = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic rst_release();
        repeat (3) tick();
        exp_q.delete();
        b_exp_q.delete();
        exp_beat = 0; lasts = 0; b_lasts = 0;
        pops = 0; hs = 0; max_held = 0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_words(input int n, input int maxc);
        int k = 0;
        while (a_words < 32'(n) && k < maxc) begin
            tick();
            k++;
        end
        check("words_out", a_words, n);
    endtask

    initial begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        #1;
        rst_assert();
        rst_release();
        check("rst_valid", a_valid, 0);
        check("rst_rd_en", a_rd_en, 0);
        check("rst_words", a_words, 0);

        // Streaming 0..39 with sink always ready
        first_rd = -1;
        first_val = -1;
        a_ready = 1'b1;
        for (int i = 0; i < 40; i++) push_a(i);
        wait_words(40, 200);
        check("latency", first_val - first_rd, 2);
        check("stream_lasts", lasts, 2);
        check("stream_drained", exp_q.size(), 0);

        // Reset asserted mid-stream with two words buffered
        a_ready = 1'b0;
        push_a(100);
        push_a(101);
        repeat (6) tick();
        check("pre_rst_valid", a_valid, 1);
        push_a(102);
        #1;
        check("pre_rst_rd_en", a_rd_en, 1);
        rst_assert();
        #1;
        check("midrst_valid", a_valid, 0);
        check("midrst_rd_en", a_rd_en, 0);
        check("midrst_words", a_words, 0);
        check("midrst_last", a_last, 0);
        rst_release();

        // Backpressure: only three words may be pulled
        rd_pulses = 0;
        for (int i = 0; i < 10; i++) push_a(i);
        repeat (12) tick();
        check("bp_pulses", rd_pulses, 3);
        check("bp_valid", a_valid, 1);
        check("bp_data", a_data, 0);
        a_ready = 1'b1;
        wait_words(10, 100);
        check("bp_drained", exp_q.size(), 0);

        // Random ready and random writes over 1000 words
        rst_assert();
        rst_release();
        begin
            int sent = 0;
            int k = 0;
            while (a_words < 32'd1000 && k < 20000) begin
                if (sent < 1000 && $urandom_range(0, 9) < 4 &&
                    a_wcnt - a_rcnt < 250) begin
                    push_a($urandom);
                    sent++;
                end
                a_ready = 1'($urandom_range(0, 1));
                tick();
                k++;
            end
        end
        check("rand_words", a_words, 1000);
        check("rand_lasts", lasts, 62);
        check("rand_held_le3", max_held <= 3, 1);
        check("rand_drained", exp_q.size(), 0);

        // FIFO runs dry mid-burst; framing resumes at the same beat
        rst_assert();
        rst_release();
        a_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_a(32'h500 + i);
        repeat (25) tick();
        check("gap_words", a_words, 5);
        check("gap_valid", a_valid, 0);
        check("gap_lasts", lasts, 0);
        for (int i = 5; i < 16; i++) push_a(32'h500 + i);
        wait_words(16, 100);
        check("gap_lasts_end", lasts, 1);

        // BURST_LEN=1 instance frames every beat
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_b(32'hb0 + i);
        begin
            int k = 0;
            while (b_words < 32'd4 && k < 100) begin
                tick();
                k++;
            end
        end
        tick();
        check("b_words", b_words, 4);
        check("b_lasts", b_lasts, 4);
        check("b_drained", b_exp_q.size(), 0);

        check("hold_stable", stable_err, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
